// File: rtl/adder_rr_sequencer.sv
// Round-robin sequencer sharing one 8-bit adder slice among NREQ requesters.
// Operands are added one byte per cycle, LSB first, with a registered carry chain.
module adder_rr_sequencer #(
    parameter int NREQ     = 4,
    parameter int MAXBYTES = 4,
    localparam int W  = 8 * MAXBYTES,
    localparam int LW = (MAXBYTES > 1) ? $clog2(MAXBYTES) : 1,
    localparam int IW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*W-1:0]  req_a,
    input  logic [NREQ*W-1:0]  req_b,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [7:0]         add_a,
    output logic [7:0]         add_b,
    output logic               add_cin,
    input  logic [7:0]         add_sum,
    input  logic               add_cout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_cout,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] last;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [LW-1:0] len;
    logic [LW-1:0] k;
    logic          carry;
    logic [IW-1:0] grant;
    logic [IW-1:0] gidx;
    logic          any;

    // Search from the slot after the last winner, wrapping around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        for (int j = 1; j <= NREQ; j++) begin
            gidx = IW'((int'(last) + j) % NREQ);
            if (!any && req_valid[gidx]) begin
                any   = 1'b1;
                grant = gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any) state_nx = RUN;
            RUN:     if (k == len) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state == IDLE && any) begin
            req_ready[grant] = 1'b1;
        end
        if (state == RUN) begin
            add_a   = op_a[{k, 3'b000} +: 8];
            add_b   = op_b[{k, 3'b000} +: 8];
            add_cin = carry;
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= IW'(NREQ - 1);
            op_a     <= '0;
            op_b     <= '0;
            len      <= '0;
            k        <= '0;
            carry    <= 1'b0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        op_a    <= req_a[int'(grant)*W +: W];
                        op_b    <= req_b[int'(grant)*W +: W];
                        len     <= req_len[int'(grant)*LW +: LW];
                        last    <= grant;
                        rsp_id  <= grant;
                        rsp_sum <= '0;
                        k       <= '0;
                        carry   <= 1'b0;
                    end
                end
                RUN: begin
                    rsp_sum[{k, 3'b000} +: 8] <= add_sum;
                    carry <= add_cout;
                    k     <= k + LW'(1);
                    if (k == len) begin
                        rsp_cout <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adder_rr_sequencer.md
# adder_rr_sequencer

Round-robin scheduler that shares one combinational 8-bit carry-select adder slice among `NREQ` requesters. Each requester submits a multi-byte add of up to `MAXBYTES` bytes. The block time-multiplexes the slice one byte per cycle, LSB first, and chains the carry between bytes in a register. It sits between the requester ports and the adder slice, and returns the assembled sum with the requester's ID on a single held response channel.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `MAXBYTES`, 4: maximum operand length in bytes. `W = 8*MAXBYTES`, `LW = clog2(MAXBYTES)` (min 1), `IW = clog2(NREQ)`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `req_valid`, in, NREQ: per-requester request valid.
- `req_ready`, out, NREQ: per-requester accept. At most one bit is set.
- `req_a`, in, NREQ*W: operand A. Requester i occupies bits `[i*W +: W]`.
- `req_b`, in, NREQ*W: operand B, same packing.
- `req_len`, in, NREQ*LW: byte count minus 1. Requester i occupies bits `[i*LW +: LW]`.
- `add_a`, out, 8: byte A driven to the adder slice.
- `add_b`, out, 8: byte B driven to the adder slice.
- `add_cin`, out, 1: carry-in to the adder slice.
- `add_sum`, in, 8: slice sum, combinational from `add_a`/`add_b`/`add_cin`.
- `add_cout`, in, 1: slice carry-out.
- `rsp_valid`, out, 1: result valid, held until accepted.
- `rsp_ready`, in, 1: consumer accept.
- `rsp_id`, out, IW: index of the requester served.
- `rsp_sum`, out, W: result. Bytes above `len` are zero.
- `rsp_cout`, out, 1: carry-out of the final byte.
- `busy`, out, 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_cout=0`, `busy=0`, `add_a=0`, `add_b=0`, `add_cin=0`. Internal: byte index 0, carry register 0, round-robin pointer `last=NREQ-1`.
- **IDLE**
  - Grant `g` = first `i` with `req_valid[i]=1`, searching from `(last+1) mod NREQ` upward with wrap.
  - `req_ready` = one-hot(`g`), combinational, only in IDLE and only when some `req_valid` is set.
  - On the handshake:
    - capture `req_a[g]`, `req_b[g]`, `req_len[g]`;
    - set `last=g`, `rsp_id=g`;
    - clear `rsp_sum`, set byte index k=0, clear the carry register;
    - go to RUN.
- **RUN** (one byte per cycle)
  - Drive `add_a` = A byte k, `add_b` = B byte k, `add_cin` = carry register.
  - On the clock edge: `rsp_sum` byte k ← `add_sum`; carry register ← `add_cout`; k ← k+1.
  - When k equals the captured `len`: `rsp_cout` ← `add_cout`, go to DONE.
  - `req_ready=0` throughout RUN.
- **DONE**
  - `rsp_valid=1`; `rsp_id`, `rsp_sum`, `rsp_cout` stable.
  - On `rsp_ready=1`: go to IDLE, `rsp_valid` deasserts next cycle.
  - `req_ready=0` throughout DONE, so a new grant happens no earlier than the cycle after the response handshake.
- Adder outputs are 0 in IDLE and DONE. `add_sum`/`add_cout` are ignored outside RUN.
- Requests that are not granted must hold their operands stable while `req_valid` is high. The block never drops a request once `req_valid` is asserted.
- Arithmetic: unsigned, modulo 2^(8*(len+1)), with the overflow reported in `rsp_cout`. The first byte's carry-in is always 0.
- Reset in any state: everything returns to its reset value on that edge. Any in-flight transaction is discarded with no response. `rsp_valid` is low the cycle after.

## Timing
- Request accepted at edge T (IDLE, `valid&ready`).
- RUN occupies cycles T+1 .. T+len+1.
- `rsp_valid` is high from cycle T+len+2.
- Minimum latency: 2 cycles for 1 byte, 5 cycles for 4 bytes.
- Throughput with `rsp_ready` tied high: one transaction per len+3 cycles (accept, len+1 RUN cycles, DONE).
- `req_ready` and `add_*` are combinational from state/registers/`req_valid`. All other outputs are registered.
- Adder slice path: the `add_a` → `add_sum` → register path must close within one cycle.

## Test plan
- Single byte: req0 `a=0x3C`, `b=0x4D`, `len=0` → `rsp_valid` 2 cycles after accept, `rsp_id=0`, `rsp_sum=0x00000089`, `rsp_cout=0`.
- Carry chain: req2 `a=0xFFFFFFFF`, `b=0x00000001`, `len=3` → 4 RUN cycles with `add_cin` sequence 0,1,1,1 → `rsp_sum=0x00000000`, `rsp_cout=1`, `rsp_id=2`.
- Length masking: req1 `a=0x12345678`, `b=0x0000FFFF`, `len=1` → `rsp_sum=0x00005677`, `rsp_cout=1`; upper bytes stay 0.
- Round-robin: all four `req_valid` held high, 1-byte adds, `rsp_ready=1` → grant order 0,1,2,3,0, one grant every 3 cycles; `req_ready` always one-hot or zero.
- Backpressure: hold `rsp_ready=0` for 3 cycles in DONE with req3 valid → `rsp_valid` and data stable, `req_ready=0`. Then raise `rsp_ready` → req3 is granted in the cycle after the handshake.
- Reset mid-RUN: assert `rst` on the second byte of a 4-byte add → next cycle FSM in IDLE, all outputs 0. No response for the aborted transaction. A following request completes correctly, starting from requester 0.
